roach_dram_write: RTL and testbench
===================================

Name: roach_dram_write

Overview:
- Sequential streaming writer for the ROACH2 DRAM command interface.
- Accepts a stream of 288-bit words and pairs them into two-beat write commands (one address per pair) at consecutive addresses starting from 0.
- Sits between a data producer (ADC/packetizer capture path) and the DRAM block's command inputs.
- Counterpart to the DRAM burst reader: it fills memory in the same address order the reader walks it.

Parameters:
- ADDR_WIDTH, 25, DRAM command address width; one address holds two 288-bit beats.
- DATA_WIDTH, 288, beat width; wr_be width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- write_en  in  1  arms the writer; when low, din_ready=0 and no new word is accepted
- restart  in  1  rising edge while no command is pending: address/finish/count cleared to 0
- flush  in  1  rising edge while exactly one word is buffered: issue that word with the second beat padded
- din  in  DATA_WIDTH  input word
- din_valid  in  1  din qualifier
- din_ready  out  1  word accepted when din_valid & din_ready
- dram_addr  out  ADDR_WIDTH  command address
- dram_data  out  DATA_WIDTH  write beat
- wr_be  out  DATA_WIDTH/8  byte enables
- rwn  out  1  0 = write; 1 whenever cmd_valid=0
- cmd_valid  out  1  beat valid
- cmd_ack  in  1  beat accepted when cmd_valid & cmd_ack
- words_written  out  32  accepted input words since reset/restart
- finish  out  1  sticky: last address written, memory full

Behaviour:
- Reset values:
  - cmd_valid=0, rwn=1, dram_addr=0, dram_data=0, wr_be=0.
  - finish=0, words_written=0, buffer empty.
  - din_ready follows write_en (combinational).
- Storage: lo/hi registers plus lo_valid flag. FSM states: EMPTY, HALF, BEAT0, BEAT1, DONE.
- EMPTY:
  - Accepted word goes to lo; next state HALF.
- HALF:
  - Accepted word goes to hi; next state BEAT0.
  - Flush edge with no accept: hi:=0, pad flag set; next state BEAT0.
  - Accept and flush in the same cycle: accept wins; the flush is ignored.
- BEAT0:
  - Outputs: cmd_valid=1, rwn=0, dram_data=lo, wr_be all ones.
  - din_ready=0.
  - Hold until cmd_ack, then go to BEAT1; lo_valid cleared.
- BEAT1:
  - Outputs: cmd_valid=1, rwn=0, dram_data=hi, same dram_addr.
  - wr_be = all ones, or 0 when padded.
  - din_ready = write_en & ~lo_valid; a word accepted here loads lo and sets lo_valid.
  - On cmd_ack: clear pad flag and increment dram_addr.
    - Next state: HALF if lo_valid, else EMPTY.
    - If dram_addr was 2^ADDR_WIDTH-1: next state DONE, finish=1, any word in lo is discarded, dram_addr wraps to 0.
- DONE:
  - din_ready=0, cmd_valid=0; all input ignored.
  - Only restart or rst leaves DONE, going to EMPTY.
- Beat timing:
  - A beat is held unchanged (data, addr, wr_be) across any number of cmd_ack=0 cycles.
  - With cmd_ack tied high: BEAT0/BEAT1 occupy exactly one cycle each.
  - First beat appears the cycle after the second word is accepted.
  - Sustained throughput: 2 words per 3 cycles.
- restart:
  - Ignored in BEAT0/BEAT1.
  - In EMPTY/HALF/DONE: clears dram_addr, finish and words_written, and discards the buffered word.
- words_written: +1 per accepted word, wraps at 2^32; pad beats are not counted.
- Edges on restart/flush are detected with one registered copy of each input.
- rst mid-command: cmd_valid drops the next cycle and the buffered data is lost.

Test Plan:
- Reset, write_en=1, cmd_ack=1, push words W0..W3 back-to-back:
  - cmd beats (addr0,W0),(addr0,W1),(addr1,W2),(addr1,W3), all with rwn=0 and wr_be=36'hFFFFFFFFF.
  - words_written=4; din_ready low exactly in the BEAT0 cycles.
- Same stimulus with cmd_ack low for 3 cycles during beat W1:
  - W1 and addr0 are held stable for those cycles.
  - No beat is duplicated or dropped; W2 is issued at addr1.
- Push a single word A, then pulse flush:
  - beats (addr0,A,wr_be all ones), then (addr0,0,wr_be=0); next word goes to addr1.
- ADDR_WIDTH=3, push 16 words:
  - finish rises after the ack of the beat at addr7.
  - din_ready=0 afterwards, a 17th word is never accepted, and dram_addr=0.
  - Then pulse restart: finish=0, words_written=0, and a new pair is written at addr0.
- Assert rst while in BEAT1:
  - next cycle cmd_valid=0, rwn=1, finish=0, words_written=0.
  - The next pair is written at addr0.
- write_en=0 with din_valid=1 for 10 cycles:
  - din_ready=0, no cmd_valid, words_written stays 0.

Source files
------------

// File: rtl/roach_dram_write.sv
// roach_dram_write: pairs a stream of DATA_WIDTH words into two-beat DRAM
// write commands at consecutive addresses, starting from address 0.
module roach_dram_write #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 288
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic                    restart,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [ADDR_WIDTH-1:0]   dram_addr,
    output logic [DATA_WIDTH-1:0]   dram_data,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    rwn,
    output logic                    cmd_valid,
    input  logic                    cmd_ack,
    output logic [31:0]             words_written,
    output logic                    finish
);

    typedef enum logic [2:0] {EMPTY, HALF, BEAT0, BEAT1, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   lo;
    logic [DATA_WIDTH-1:0]   hi;
    logic                    lo_valid;
    logic                    pad;
    logic                    restart_q;
    logic                    flush_q;

    logic                    restart_edge;
    logic                    flush_edge;
    logic                    last_addr;
    logic                    load_lo;
    logic                    load_hi;
    logic                    pad_hi;
    logic                    beat0_done;
    logic                    beat1_done;
    logic                    do_restart;

    assign restart_edge = restart & ~restart_q;
    assign flush_edge   = flush & ~flush_q;
    assign last_addr    = (dram_addr == {ADDR_WIDTH{1'b1}});
    assign rwn          = ~cmd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state, command outputs and datapath control strobes
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        cmd_valid  = 1'b0;
        dram_data  = '0;
        wr_be      = '0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        pad_hi     = 1'b0;
        beat0_done = 1'b0;
        beat1_done = 1'b0;
        do_restart = 1'b0;
        case (state)
            EMPTY: begin
                if (restart_edge) begin
                    do_restart = 1'b1;
                end else begin
                    din_ready = write_en;
                    if (din_valid && din_ready) begin
                        load_lo    = 1'b1;
                        state_next = HALF;
                    end
                end
            end
            HALF: begin
                if (restart_edge) begin
                    do_restart = 1'b1;
                    state_next = EMPTY;
                end else begin
                    din_ready = write_en;
                    if (din_valid && din_ready) begin
                        load_hi    = 1'b1;
                        state_next = BEAT0;
                    end else if (flush_edge) begin
                        pad_hi     = 1'b1;
                        state_next = BEAT0;
                    end
                end
            end
            BEAT0: begin
                cmd_valid = 1'b1;
                dram_data = lo;
                wr_be     = '1;
                if (cmd_ack) begin
                    beat0_done = 1'b1;
                    state_next = BEAT1;
                end
            end
            BEAT1: begin
                cmd_valid = 1'b1;
                dram_data = hi;
                wr_be     = pad ? '0 : '1;
                din_ready = write_en & ~lo_valid;
                if (din_valid && din_ready) begin
                    load_lo = 1'b1;
                end
                if (cmd_ack) begin
                    beat1_done = 1'b1;
                    if (last_addr) begin
                        state_next = DONE;
                    end else if (lo_valid || load_lo) begin
                        state_next = HALF;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            DONE: begin
                if (restart_edge) begin
                    do_restart = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Word buffers, address/finish/count bookkeeping and input edge detectors
    always_ff @(posedge clk) begin
        if (rst) begin
            lo            <= '0;
            hi            <= '0;
            lo_valid      <= 1'b0;
            pad           <= 1'b0;
            dram_addr     <= '0;
            finish        <= 1'b0;
            words_written <= '0;
            restart_q     <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            restart_q <= restart;
            flush_q   <= flush;

            if (load_lo) begin
                lo <= din;
            end
            if (load_hi) begin
                hi <= din;
            end else if (pad_hi) begin
                hi <= '0;
            end

            if (pad_hi) begin
                pad <= 1'b1;
            end else if (beat1_done) begin
                pad <= 1'b0;
            end

            if (do_restart || beat0_done) begin
                lo_valid <= 1'b0;
            end else if (beat1_done && last_addr) begin
                lo_valid <= 1'b0;
            end else if (load_lo) begin
                lo_valid <= 1'b1;
            end

            if (do_restart) begin
                dram_addr <= '0;
            end else if (beat1_done) begin
                dram_addr <= dram_addr + ADDR_WIDTH'(1);
            end

            if (do_restart) begin
                finish <= 1'b0;
            end else if (beat1_done && last_addr) begin
                finish <= 1'b1;
            end

            if (do_restart) begin
                words_written <= '0;
            end else if (load_lo || load_hi) begin
                words_written <= words_written + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_roach_dram_write.sv
// Directed bench for roach_dram_write, built with a 3-bit address so the
// memory-full path is reachable in a handful of cycles.
module tb_roach_dram_write;

    localparam int AW = 3;
    localparam int DW = 288;
    localparam int BW = DW / 8;
    localparam logic [BW-1:0] BE_ALL = '1;

    logic              clk;
    logic              rst;
    logic              write_en;
    logic              restart;
    logic              flush;
    logic [DW-1:0]     din;
    logic              din_valid;
    logic              din_ready;
    logic [AW-1:0]     dram_addr;
    logic [DW-1:0]     dram_data;
    logic [BW-1:0]     wr_be;
    logic              rwn;
    logic              cmd_valid;
    logic              cmd_ack;
    logic [31:0]       words_written;
    logic              finish;

    int compared   = 0;
    int mismatched = 0;

    roach_dram_write #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .restart       (restart),
        .flush         (flush),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dram_addr     (dram_addr),
        .dram_data     (dram_data),
        .wr_be         (wr_be),
        .rwn           (rwn),
        .cmd_valid     (cmd_valid),
        .cmd_ack       (cmd_ack),
        .words_written (words_written),
        .finish        (finish)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct test word for index i
    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] s;
        s = 32'hC0DE_0000 + 32'(i);
        return {32'(i) ^ 32'h5A5A_0000, {8{s}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all non-reset inputs, then let combinational outputs settle
    task automatic applyStimulus(input logic we, input logic rs, input logic fl,
                                 input logic [DW-1:0] d, input logic dv, input logic ack);
        write_en  = we;
        restart   = rs;
        flush     = fl;
        din       = d;
        din_valid = dv;
        cmd_ack   = ack;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        int k;
        int b;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Reset values
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_rwn", rwn, 1);
        checkOutput("rst_addr", dram_addr, 0);
        checkOutput("rst_data", dram_data, 0);
        checkOutput("rst_be", wr_be, 0);
        checkOutput("rst_finish", finish, 0);
        checkOutput("rst_words", words_written, 0);
        checkOutput("rst_ready_we1", din_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("rst_ready_we0", din_ready, 0);

        // Back-to-back W0..W3 with ack tied high
        $display("[TB] back-to-back stream");
        applyStimulus(1'b1, 1'b0, 1'b0, mk(0), 1'b1, 1'b1);
        checkOutput("b2b_ready0", din_ready, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(1), 1'b1, 1'b1);
        checkOutput("b2b_ready1", din_ready, 1);
        checkOutput("b2b_idle_valid", cmd_valid, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(2), 1'b1, 1'b1);
        checkOutput("b2b_beat0_ready", din_ready, 0);
        checkOutput("b2b_beat0_valid", cmd_valid, 1);
        checkOutput("b2b_beat0_rwn", rwn, 0);
        checkOutput("b2b_beat0_addr", dram_addr, 0);
        checkOutput("b2b_beat0_data", dram_data, mk(0));
        checkOutput("b2b_beat0_be", wr_be, BE_ALL);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(2), 1'b1, 1'b1);
        checkOutput("b2b_beat1_ready", din_ready, 1);
        checkOutput("b2b_beat1_addr", dram_addr, 0);
        checkOutput("b2b_beat1_data", dram_data, mk(1));
        checkOutput("b2b_beat1_be", wr_be, BE_ALL);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(3), 1'b1, 1'b1);
        checkOutput("b2b_half_ready", din_ready, 1);
        checkOutput("b2b_half_valid", cmd_valid, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("b2b_beat2_ready", din_ready, 0);
        checkOutput("b2b_beat2_addr", dram_addr, 1);
        checkOutput("b2b_beat2_data", dram_data, mk(2));
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("b2b_beat3_addr", dram_addr, 1);
        checkOutput("b2b_beat3_data", dram_data, mk(3));
        checkOutput("b2b_beat3_rwn", rwn, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("b2b_end_valid", cmd_valid, 0);
        checkOutput("b2b_end_words", words_written, 4);
        checkOutput("b2b_end_addr", dram_addr, 2);

        // Same stream with the W1 beat stalled for three cycles
        $display("[TB] stalled beat");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(0), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(1), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(2), 1'b1, 1'b1);
        checkOutput("stall_beat0_data", dram_data, mk(0));
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, (i == 0) ? mk(2) : mk(3), 1'b1, 1'b0);
            checkOutput("stall_hold_valid", cmd_valid, 1);
            checkOutput("stall_hold_data", dram_data, mk(1));
            checkOutput("stall_hold_addr", dram_addr, 0);
            checkOutput("stall_hold_be", wr_be, BE_ALL);
            checkOutput("stall_hold_ready", din_ready, (i == 0) ? 1 : 0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, mk(3), 1'b1, 1'b1);
        checkOutput("stall_release_data", dram_data, mk(1));
        checkOutput("stall_release_ready", din_ready, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(3), 1'b1, 1'b1);
        checkOutput("stall_half_valid", cmd_valid, 0);
        checkOutput("stall_half_ready", din_ready, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("stall_w2_data", dram_data, mk(2));
        checkOutput("stall_w2_addr", dram_addr, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("stall_w3_data", dram_data, mk(3));
        checkOutput("stall_w3_addr", dram_addr, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(4), 1'b0, 1'b1);
        checkOutput("stall_words", words_written, 4);
        checkOutput("stall_addr_end", dram_addr, 2);

        // Single word then flush: second beat padded
        $display("[TB] flush");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(10), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, mk(11), 1'b0, 1'b1);
        checkOutput("flush_half_valid", cmd_valid, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(11), 1'b0, 1'b1);
        checkOutput("flush_beat0_valid", cmd_valid, 1);
        checkOutput("flush_beat0_data", dram_data, mk(10));
        checkOutput("flush_beat0_be", wr_be, BE_ALL);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(11), 1'b0, 1'b1);
        checkOutput("flush_pad_valid", cmd_valid, 1);
        checkOutput("flush_pad_data", dram_data, 0);
        checkOutput("flush_pad_be", wr_be, 0);
        checkOutput("flush_pad_addr", dram_addr, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(11), 1'b1, 1'b1);
        checkOutput("flush_words", words_written, 1);
        checkOutput("flush_next_addr", dram_addr, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(12), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(13), 1'b0, 1'b1);
        checkOutput("flush_next_data", dram_data, mk(11));
        checkOutput("flush_next_baddr", dram_addr, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(13), 1'b0, 1'b1);
        checkOutput("flush_next_be", wr_be, BE_ALL);
        checkOutput("flush_next_data2", dram_data, mk(12));
        tick();

        // Fill all eight addresses, check finish, then restart
        $display("[TB] fill to finish");
        doReset();
        k = 0;
        b = 0;
        for (int cyc = 0; cyc < 80 && b < 16; cyc++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, mk(100 + k), (k < 16), 1'b1);
            if (din_valid && din_ready) k++;
            if (cmd_valid) begin
                checkOutput("fill_data", dram_data, mk(100 + b));
                checkOutput("fill_addr", dram_addr, DW'(b / 2));
                checkOutput("fill_finish_low", finish, 0);
                b++;
            end
            tick();
        end
        checkOutput("fill_beat_count", DW'(b), 16);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, mk(116), 1'b1, 1'b1);
            checkOutput("done_finish", finish, 1);
            checkOutput("done_ready", din_ready, 0);
            checkOutput("done_valid", cmd_valid, 0);
            checkOutput("done_addr", dram_addr, 0);
            checkOutput("done_words", words_written, 16);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, mk(116), 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(120), 1'b1, 1'b1);
        checkOutput("restart_finish", finish, 0);
        checkOutput("restart_words", words_written, 0);
        checkOutput("restart_ready", din_ready, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(121), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(122), 1'b0, 1'b1);
        checkOutput("restart_beat_addr", dram_addr, 0);
        checkOutput("restart_beat_data", dram_data, mk(120));
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(122), 1'b0, 1'b1);
        checkOutput("restart_beat1_data", dram_data, mk(121));
        tick();

        // Reset while the second beat is on the bus
        $display("[TB] reset mid-command");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(30), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(31), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(32), 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(32), 1'b1, 1'b1);
        checkOutput("mid_pre_addr", dram_addr, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(33), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(34), 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, mk(34), 1'b0, 1'b1);
        checkOutput("mid_beat1_data", dram_data, mk(33));
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, mk(40), 1'b1, 1'b1);
        checkOutput("mid_valid", cmd_valid, 0);
        checkOutput("mid_rwn", rwn, 1);
        checkOutput("mid_finish", finish, 0);
        checkOutput("mid_words", words_written, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(41), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(42), 1'b0, 1'b1);
        checkOutput("mid_next_addr", dram_addr, 0);
        checkOutput("mid_next_data", dram_data, mk(40));
        tick();

        // write_en low blocks everything
        $display("[TB] write_en low");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, mk(50 + i), 1'b1, 1'b1);
            checkOutput("we0_ready", din_ready, 0);
            checkOutput("we0_valid", cmd_valid, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, mk(60), 1'b0, 1'b1);
        checkOutput("we0_words", words_written, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
